// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a 1-entry skid
// buffer, stall backpressure and EX/MEM redirect with wrong-path kill.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        ex_mem_taken,
  input  logic [31:0] ex_mem_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);

  fetch_state_t state_q, state_d;

  logic        run_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic        skid_valid_q, skid_valid_d;
  logic        slot_free;

  // run_q keeps imem_req low until the first edge after reset release
  assign imem_req  = run_q && (state_q == REQ);
  assign imem_addr = fetch_pc_q;
  assign slot_free = !valid_q || !stall;

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    skid_pc_d    = skid_pc_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (valid_q && !stall) valid_d = 1'b0;

    unique case (state_q)
      REQ: begin
        if (imem_req && imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          unique case (1'b1)
            kill_q: kill_d = 1'b0;
            (!kill_q && slot_free): begin
              pc_d       = fetch_pc_q;
              instr_d    = imem_rdata;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
            default: begin
              skid_pc_d    = fetch_pc_q;
              skid_data_d  = imem_rdata;
              skid_valid_d = 1'b1;
              fetch_pc_d   = fetch_pc_q + 32'd4;
              state_d      = HOLD;
            end
          endcase
        end
      end
      HOLD: begin
        if (slot_free && skid_valid_q) begin
          pc_d         = skid_pc_q;
          instr_d      = skid_data_q;
          valid_d      = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    // redirect wins over stall and any response landing this cycle
    if (ex_mem_taken) begin
      pc_d         = 32'd0;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      fetch_pc_d   = ex_mem_target & ~32'd3;
      unique case (state_q)
        REQ: begin
          kill_d  = imem_req && imem_gnt;
          state_d = (imem_req && imem_gnt) ? WAIT : REQ;
        end
        WAIT: begin
          kill_d  = !imem_rvalid;
          state_d = imem_rvalid ? REQ : WAIT;
        end
        HOLD:    state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      pc_q         <= 32'd0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_data_q  <= NOP_INSTR;
      skid_valid_q <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule
